// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shift/rotate unit.
//   OP_W              width of the operation code
//   sh_op_e           operation encoding; codes 101..111 pass the operand through
//   levels_per_stage  log-levels per pipeline stage, ceil(shw / pipe)
package shifter_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SH_SLL = 3'b000,
        SH_SRL = 3'b001,
        SH_SRA = 3'b010,
        SH_ROL = 3'b011,
        SH_ROR = 3'b100
    } sh_op_e;

    function automatic int unsigned levels_per_stage(input int unsigned shw,
                                                     input int unsigned pipe);
        return (shw + pipe - 1) / pipe;
    endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// Combinational slice of the log shifter: applies levels FIRST_LVL .. FIRST_LVL+N_LVL-1,
// where level j shifts/rotates by 2^j when shamt[j] is set.
//   a      operand entering this slice
//   shamt  full shift amount; only this slice's bits act here
//   op     operation code (shifter_pkg)
//   y      partially shifted result
module shifter_pipe_stage
    import shifter_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FIRST_LVL = 0,
    parameter int unsigned N_LVL     = 1,
    localparam int unsigned SHW      = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  shamt,
    input  logic [OP_W-1:0] op,
    output logic [XLEN-1:0] y
);

    // One level; amt is always < XLEN so the rotate's complementary shift is in range.
    function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] x,
                                                 input logic [OP_W-1:0] code,
                                                 input int unsigned     amt);
        logic [XLEN-1:0] r;
        case (code)
            SH_SLL:  r = x << amt;
            SH_SRL:  r = x >> amt;
            SH_SRA:  r = $signed(x) >>> amt;
            SH_ROL:  r = (x << amt) | (x >> (XLEN - amt));
            SH_ROR:  r = (x >> amt) | (x << (XLEN - amt));
            default: r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [XLEN-1:0] x;
        logic [SHW-1:0]  sel;
        x   = a;
        sel = '0;
        for (int i = 0; i < N_LVL; i++) begin
            sel = shamt >> (FIRST_LVL + i);
            if (sel[0]) begin
                x = shift_by(x, op, 1 << (FIRST_LVL + i));
            end
        end
        y = x;
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined shift/rotate unit with valid/ready handshakes on both sides.
// Results return in order PIPE cycles after acceptance; back-pressure stalls the pipe.
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kills all in-flight ops at the next edge
//   in_valid / in_ready   input handshake; in_a, in_shamt, in_op, in_tag payload
//   out_valid / out_ready output handshake; out_data, out_tag payload
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PIPE  = 2,
    parameter int unsigned TAG_W = 5,
    localparam int unsigned SHW  = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LPS = levels_per_stage(SHW, PIPE);

    logic [PIPE-1:0]             valid_q;
    logic [PIPE-1:0][XLEN-1:0]   data_q;
    logic [PIPE-1:0][SHW-1:0]    shamt_q;
    logic [PIPE-1:0][OP_W-1:0]   op_q;
    logic [PIPE-1:0][TAG_W-1:0]  tag_q;

    // Per-stage inputs and combinational results.
    logic [PIPE-1:0]             v_in;
    logic [PIPE-1:0][XLEN-1:0]   a_in;
    logic [PIPE-1:0][SHW-1:0]    sh_in;
    logic [PIPE-1:0][OP_W-1:0]   op_in;
    logic [PIPE-1:0][TAG_W-1:0]  tag_in;
    logic [PIPE-1:0][XLEN-1:0]   data_c;

    // ready[k]: register k may load this edge (empty, or everything downstream drains).
    logic [PIPE-1:0]             ready;

    always_comb begin
        logic r;
        r = out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            r        = r || !valid_q[k];
            ready[k] = r;
        end
    end

    always_comb begin
        v_in[0]   = in_valid;
        a_in[0]   = in_a;
        sh_in[0]  = in_shamt;
        op_in[0]  = in_op;
        tag_in[0] = in_tag;
        for (int k = 1; k < PIPE; k++) begin
            v_in[k]   = valid_q[k-1];
            a_in[k]   = data_q[k-1];
            sh_in[k]  = shamt_q[k-1];
            op_in[k]  = op_q[k-1];
            tag_in[k] = tag_q[k-1];
        end
    end

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        // Last stage takes the remainder, which may be zero levels for some PIPE/SHW pairs.
        localparam int unsigned FIRST = (k * LPS < SHW) ? k * LPS : SHW;
        localparam int unsigned N_LVL = (SHW - FIRST < LPS) ? SHW - FIRST : LPS;

        shifter_pipe_stage #(
            .XLEN      (XLEN),
            .FIRST_LVL (FIRST),
            .N_LVL     (N_LVL)
        ) u_stage (
            .a     (a_in[k]),
            .shamt (sh_in[k]),
            .op    (op_in[k]),
            .y     (data_c[k])
        );
    end

    // Flush beats out_ready: the op sitting on the output is discarded, not transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            tag_q   <= '0;
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (ready[k]) begin
                    valid_q[k] <= v_in[k];
                end
                if (ready[k]) begin
                    data_q[k]  <= data_c[k];
                    shamt_q[k] <= sh_in[k];
                    op_q[k]    <= op_in[k];
                    tag_q[k]   <= tag_in[k];
                end
            end
        end
    end

    // The final stage's shift amount and op have no consumer.
    logic unused_last;
    assign unused_last = ^{shamt_q[PIPE-1], op_q[PIPE-1]};

    assign in_ready  = !flush && ready[0];
    assign out_valid = valid_q[PIPE-1];
    assign out_data  = data_q[PIPE-1];
    assign out_tag   = tag_q[PIPE-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe (XLEN=32, PIPE=2, TAG_W=5): directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
module tb_shifter_pipe;

    localparam int XLEN  = 32;
    localparam int PIPE  = 2;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [4:0]  in_shamt = '0;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    shifter_pipe #(
        .XLEN  (XLEN),
        .PIPE  (PIPE),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          acc;
    } item_t;

    item_t q[$];

    // Reference semantics from plain arithmetic; rotates via a doubled operand.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [4:0] sh);
        logic [63:0] dbl;
        dbl = {a, a};
        case (op)
            3'd0: return a << sh;
            3'd1: return a >> sh;
            3'd2: return $signed(a) >>> sh;
            3'd3: begin dbl = dbl << sh; return dbl[63:32]; end
            3'd4: begin dbl = dbl >> sh; return dbl[31:0]; end
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) xfers++;
    end

    // Model: an op presented in cycle n is visible from cycle n+PIPE if nothing is ahead of it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            logic  mv;
            logic  mr;
            item_t it;
            mv = q.size() > 0 && cyc >= q[0].acc + PIPE;
            mr = q.size() < PIPE || out_ready;
            if (mv && out_ready) void'(q.pop_front());
            if (in_valid && mr) begin
                it.data = model(in_op, in_a, in_shamt);
                it.tag  = in_tag;
                it.acc  = cyc;
                q.push_back(it);
            end
        end
    end

    always @(negedge clk) begin
        logic ev;
        logic er;
        ev = rst_n && q.size() > 0 && cyc >= q[0].acc + PIPE;
        er = !flush && (!rst_n || q.size() < PIPE || out_ready);
        chk("model out_valid", 32'(out_valid), 32'(ev));
        chk("model in_ready", 32'(in_ready), 32'(er));
        if (ev) begin
            chk("model out_data", out_data, q[0].data);
            chk("model out_tag", 32'(out_tag), 32'(q[0].tag));
        end
    end

    logic [2:0]  bop  [8];
    logic [31:0] ba   [8];
    logic [4:0]  bsh  [8];
    logic [4:0]  btag [8];
    logic [31:0] bexp [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                         input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_shamt = sh;
        in_tag   = tag;
    endtask

    // Back-to-back burst on an empty pipe with out_ready high; result i lands in cycle i+PIPE.
    task automatic run_burst(input int n, input string name);
        for (int i = 0; i < n + PIPE; i++) begin
            if (i < n) drive(bop[i], ba[i], bsh[i], btag[i]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (i >= PIPE) begin
                chk({name, " valid"}, 32'(out_valid), 32'd1);
                chk({name, " data"}, out_data, bexp[i-PIPE]);
                chk({name, " tag"}, 32'(out_tag), 32'(btag[i-PIPE]));
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int base;
        #1 rst_n = 1'b0;
        #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_tag", 32'(out_tag), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // SRA latency: present in cycle c, result in cycle c+2 only.
        drive(3'b010, 32'h8000_0000, 5'd4, 5'd3);
        @(negedge clk);
        chk("sra c0 valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("sra c1 valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("sra c2 valid", 32'(out_valid), 32'd1);
        chk("sra c2 data", out_data, 32'hF800_0000);
        chk("sra c2 tag", 32'(out_tag), 32'd3);
        tick();
        @(negedge clk);
        chk("sra c3 valid", 32'(out_valid), 32'd0);
        tick();

        // Mixed ops and boundary amounts.
        bop[0] = 3'd4; ba[0] = 32'h0000_00F1; bsh[0] = 5'd4;  btag[0] = 5'd1; bexp[0] = 32'h1000_000F;
        bop[1] = 3'd3; ba[1] = 32'h8000_0001; bsh[1] = 5'd1;  btag[1] = 5'd2; bexp[1] = 32'h0000_0003;
        bop[2] = 3'd7; ba[2] = 32'h1234_5678; bsh[2] = 5'd9;  btag[2] = 5'd4; bexp[2] = 32'h1234_5678;
        bop[3] = 3'd2; ba[3] = 32'h8000_0000; bsh[3] = 5'd31; btag[3] = 5'd5; bexp[3] = 32'hFFFF_FFFF;
        bop[4] = 3'd2; ba[4] = 32'h7000_0000; bsh[4] = 5'd31; btag[4] = 5'd6; bexp[4] = 32'h0000_0000;
        bop[5] = 3'd4; ba[5] = 32'h1234_5678; bsh[5] = 5'd8;  btag[5] = 5'd7; bexp[5] = 32'h7812_3456;
        bop[6] = 3'd3; ba[6] = 32'h1234_5678; bsh[6] = 5'd4;  btag[6] = 5'd8; bexp[6] = 32'h2345_6781;
        bop[7] = 3'd1; ba[7] = 32'h8000_0000; bsh[7] = 5'd31; btag[7] = 5'd9; bexp[7] = 32'h0000_0001;
        run_burst(8, "mixed");
        tick();

        for (int i = 0; i < 8; i++) begin
            bop[i] = 3'd0; ba[i] = 32'd1; bsh[i] = 5'(i); btag[i] = 5'(i);
            bexp[i] = 32'd1 << i;
        end
        run_burst(8, "sll burst");
        tick();

        // Back-pressure: output held for three cycles while the pipe is full.
        base = xfers;
        drive(3'd0, 32'h3, 5'd1, 5'd10);
        tick();
        drive(3'd0, 32'h3, 5'd2, 5'd11);
        tick();
        drive(3'd0, 32'h3, 5'd3, 5'd12);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall valid", 32'(out_valid), 32'd1);
            chk("stall data", out_data, 32'h6);
            chk("stall tag", 32'(out_tag), 32'd10);
            if (i >= 1) chk("stall in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall transfer count", 32'(xfers - base), 32'd3);

        // Flush with two in flight and a concurrent request.
        drive(3'd1, 32'hF0, 5'd4, 5'd20);
        tick();
        drive(3'd1, 32'hF0, 5'd1, 5'd21);
        tick();
        drive(3'd0, 32'h1, 5'd1, 5'd22);
        flush = 1'b1;
        @(negedge clk);
        chk("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post-flush valid", 32'(out_valid), 32'd0);
            tick();
        end

        // Asynchronous reset mid-operation.
        drive(3'd3, 32'hDEAD_BEEF, 5'd4, 5'd7);
        tick();
        drive(3'd4, 32'hCAFE_F00D, 5'd12, 5'd8);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(out_valid), 32'd0);
        chk("async rst data", out_data, 32'd0);
        chk("async rst tag", 32'(out_tag), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post-reset valid", 32'(out_valid), 32'd0);
            tick();
        end

        // Zero shift is identity for every op code.
        for (int i = 0; i < 8; i++) begin
            bop[i] = 3'(i); ba[i] = 32'hA5C3_0F96; bsh[i] = 5'd0; btag[i] = 5'(i + 16);
            bexp[i] = 32'hA5C3_0F96;
        end
        run_burst(8, "identity");
        for (int i = 0; i < 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks,
                 errors);
        $fatal(1);
    end

endmodule
